// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. It generates the
//   stall and flush controls for load-use hazards, EX-stage redirects and
//   data-memory wait states. A memory wait that lasts too long parks the
//   block in a sticky TIMEOUT state. Only reset leaves that state.
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   id_rs1/id_rs2       : source registers of the instruction in ID
//   id_use_rs1/rs2      : the ID instruction actually reads rs1 / rs2
//   ex_rd               : destination register in ID/EX
//   ex_reg_write        : EX instruction writes the register file
//   ex_result_src       : EX result source (2'b01 = load)
//   ex_redirect         : EX resolved a taken branch / jal / jalr
//   dmem_busy           : data memory not ready, so the pipeline freezes
//   stall_*             : hold the PC / named pipeline register
//   flush_*             : zero the named pipeline register on the next edge
//   timeout_err         : sticky memory-wait timeout flag
//   stall_cycles        : saturating count of cycles with stall_pc=1
//   flush_events        : saturating count of redirect flush cycles
//   dbg_state_o         : current FSM state (0 RUN, 1 MEM_WAIT, 2 TIMEOUT)
//   dbg_wait_cnt_o      : cycles spent in MEM_WAIT (holds 255 in TIMEOUT)
//
// Handshake note: there is no valid/ready pair here. dmem_busy acts as a
// level "not ready" from memory. While it is high, every pipeline register
// holds and nothing is flushed. Work resumes in the first cycle it is low.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_result_src,
  input  logic        ex_redirect,
  input  logic        dmem_busy,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        timeout_err,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
  output logic [1:0]  dbg_state_o,
  output logic [7:0]  dbg_wait_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TIMEOUT  = 2'd2,
    S_ILLEGAL  = 2'd3
  } state_e;

  localparam logic [1:0]  RES_SRC_LOAD = 2'b01;
  localparam logic [7:0]  WAIT_MAX     = 8'd255;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic        timeout_err_q;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  logic load_use;
  logic freeze;
  logic redirect_act;
  logic bubble;

  // x0 is hardwired to zero, so a load "writing" it never creates a hazard.
  always_comb begin
    load_use = ex_reg_write && (ex_result_src == RES_SRC_LOAD) && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Priority: TIMEOUT / memory freeze > redirect > load-use bubble.
  // A redirect seen during the freeze is not latched. EX is frozen, so
  // ex_redirect is still asserted once dmem_busy drops.
  always_comb begin
    freeze       = (state_q == S_TIMEOUT) || dmem_busy;
    redirect_act = !freeze && ex_redirect;
    bubble       = !freeze && !ex_redirect && load_use;
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  always_comb begin
    stall_pc    = !rst && (freeze || bubble);
    stall_ifid  = !rst && (freeze || bubble);
    stall_idex  = !rst && freeze;
    stall_exmem = !rst && freeze;
    flush_ifid  = !rst && redirect_act;
    flush_idex  = !rst && (redirect_act || bubble);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    flush_events_d = flush_events_q;
    if (redirect_act && (flush_events_q != CNT_MAX)) begin
      flush_events_d = flush_events_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= 8'd0;
      timeout_err_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      case (state_q)
        S_RUN: begin
          if (dmem_busy) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        S_MEM_WAIT: begin
          if (!dmem_busy) begin
            state_q    <= S_RUN;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q == WAIT_MAX) begin
            // Counter stays at 255 rather than wrapping.
            state_q       <= S_TIMEOUT;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_TIMEOUT: begin
          state_q <= S_TIMEOUT;
        end
        default: begin
          state_q    <= S_RUN;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign timeout_err    = timeout_err_q;
  assign stall_cycles   = stall_cycles_q;
  assign flush_events   = flush_events_q;
  assign dbg_state_o    = state_q;
  assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed plus randomized bench for hazard_ctrl. A behavioural reference
//   model tracks the consecutive busy-cycle run length, a sticky timed-out
//   flag and unbounded event tallies. Saturation is applied only at compare
//   time. Expected control vectors pass through exp_q.
module tb_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, ex_reg_write = 0;
  logic [1:0]  ex_result_src = '0;
  logic        ex_redirect = 0, dmem_busy = 0;

  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex;
  logic        timeout_err;
  logic [15:0] stall_cycles, flush_events;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_wait_cnt;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .timeout_err(timeout_err), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .dbg_state_o(dbg_state), .dbg_wait_cnt_o(dbg_wait_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  // reference model state
  bit m_timed_out = 0;
  int m_busy_run  = 0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex}
  function automatic logic [5:0] model_out();
    bit hit;
    hit = ex_reg_write && (ex_result_src == 2'b01) && (ex_rd != 0) &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst)                         return 6'b000000;
    if (m_timed_out || dmem_busy)    return 6'b111100;
    if (ex_redirect)                 return 6'b000011;
    if (hit)                         return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic check_regs(input string tag);
    int exp_state;
    int exp_wait;
    exp_state = m_timed_out ? 2 : ((m_busy_run > 0) ? 1 : 0);
    exp_wait  = m_timed_out ? 255 : m_busy_run;
    check({tag, ".state"},        32'(dbg_state),    32'(exp_state));
    check({tag, ".wait_cnt"},     32'(dbg_wait_cnt), 32'(exp_wait));
    check({tag, ".timeout_err"},  32'(timeout_err),  32'(m_timed_out));
    check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(sat16(m_stalls)));
    check({tag, ".flush_events"}, 32'(flush_events), 32'(sat16(m_flushes)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_result_src = 0;
    ex_redirect = 0; dmem_busy = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    set_idle();
    ex_reg_write = 1; ex_result_src = 2'b01; ex_rd = rd;
    id_use_rs2 = 1; id_rs2 = rd;
  endtask

  // One clock cycle: inputs are already driven (just after a rising edge).
  // Combinational controls are checked mid-cycle, registers after the edge.
  task automatic step(input string tag, input bit full);
    logic [5:0] e;
    #2;
    e = model_out();
    exp_q.push_back(e);
    check({tag, ".ctrl"},
          {26'd0, stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex},
          {26'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    if (!rst) begin
      if (e[5]) m_stalls++;
      if (!m_timed_out && !dmem_busy && ex_redirect) m_flushes++;
      if (!m_timed_out) begin
        if (dmem_busy) begin
          m_busy_run++;
          if (m_busy_run == 256) m_timed_out = 1;
        end else begin
          m_busy_run = 0;
        end
      end
    end
    if (full) check_regs(tag);
  endtask

  // Reset raised mid-cycle with random inputs. Clearing must be immediate.
  task automatic do_reset(input string tag);
    id_rs1 = 5'($urandom_range(0, 31)); id_rs2 = id_rs1; ex_rd = id_rs1;
    id_use_rs1 = 1; ex_reg_write = 1; ex_result_src = 2'b01;
    dmem_busy = 1'($urandom_range(0, 1)); ex_redirect = 1'($urandom_range(0, 1));
    rst = 1;
    m_timed_out = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0;
    #1;
    check_regs({tag, ".async"});
    step({tag, ".held"}, 1);
    rst = 0;
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    @(posedge clk);
    #1;
    do_reset("reset");

    // load-use hazard on rs2
    set_load_use(5'd5);
    step("lu", 1);
    check("lu.stall_cycles_is_1", 32'(stall_cycles), 32'd1);

    // x0 never hazards
    set_load_use(5'd0);
    id_use_rs1 = 1; id_rs1 = 0;
    step("x0", 1);
    check("x0.stall_cycles_same", 32'(stall_cycles), 32'd1);

    // redirect outranks load-use
    set_load_use(5'd7);
    ex_redirect = 1;
    step("redir_lu", 1);
    check("redir_lu.flush_events_is_1", 32'(flush_events), 32'd1);

    // 10-cycle memory wait with redirect held throughout
    do_reset("rst_mw");
    ex_redirect = 1; dmem_busy = 1;
    for (int i = 0; i < 10; i++) step("memwait", 1);
    check("memwait.wait_cnt_10", 32'(dbg_wait_cnt), 32'd10);
    check("memwait.stall_cycles_10", 32'(stall_cycles), 32'd10);
    dmem_busy = 0;
    step("memwait_release", 1);
    check("memwait_release.run", 32'(dbg_state), 32'd0);
    check("memwait_release.flush_events", 32'(flush_events), 32'd1);
    set_idle();
    step("memwait_idle", 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 7)); ex_reg_write = ($urandom_range(0, 3) != 0);
      ex_result_src = 2'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 4) == 0);
      dmem_busy = ($urandom_range(0, 5) == 0);
      step("rand", 1);
    end

    // timeout after 256 busy cycles
    do_reset("rst_to");
    dmem_busy = 1; ex_redirect = 1;
    for (int i = 0; i < 300; i++) begin
      step("timeout", 1);
      if (i == 254) check("timeout.still_wait_255", 32'(dbg_state), 32'd1);
      if (i == 255) check("timeout.entered_256", 32'(dbg_state), 32'd2);
    end
    check("timeout.err", 32'(timeout_err), 32'd1);
    set_idle();
    set_load_use(5'd3);
    for (int i = 0; i < 5; i++) step("timeout_sticky", 1);
    check("timeout.stall_pc_after_busy", 32'(stall_pc), 32'd1);
    do_reset("rst_from_to");
    check("rst_from_to.err_clear", 32'(timeout_err), 32'd0);

    // reset mid-MEM_WAIT
    dmem_busy = 1;
    for (int i = 0; i < 4; i++) step("mw_pre_rst", 1);
    do_reset("rst_mid_mw");

    // saturation of stall_cycles
    set_load_use(5'd9);
    for (int i = 0; i < 70000; i++) step("sat", (i % 97 == 0) || (i > 69990));
    check("sat.stall_cycles_ffff", 32'(stall_cycles), 32'h0000FFFF);
    step("sat_hold", 1);
    check("sat_hold.stall_cycles_ffff", 32'(stall_cycles), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide ports:
- clk, in, 1: single clock; all state updates on rising edge.
- rst, in, 1: reset, asynchronous, active-high; one clock, no other clock domains.
- id_rs1, id_rs2, in, 5 each: source registers of the instruction in ID.
- id_use_rs1, id_use_rs2, in, 1 each: the ID instruction reads rs1 / rs2.
- ex_rd, in, 5: destination register held in the ID/EX register.
- ex_reg_write, in, 1: EX instruction writes the register file.
- ex_result_src, in, 2: EX result source; 2'b01 = load.
- ex_redirect, in, 1: EX resolved a taken branch, jal or jalr.
- dmem_busy, in, 1: data memory not ready; the pipeline must freeze.
- stall_pc, stall_ifid, stall_idex, stall_exmem, out, 1 each: hold the PC or the named pipeline register.
- flush_ifid, flush_idex, out, 1 each: zero the named pipeline register next edge.
- timeout_err, out, 1: sticky memory-wait timeout flag.
- stall_cycles, out, 16: saturating count of cycles with stall_pc=1.
- flush_events, out, 16: saturating count of redirect flush cycles.

Function
REQ-002 SHALL hold a 2-bit state register: RUN=0, MEM_WAIT=1, TIMEOUT=2; encoding 3 SHALL go to RUN next edge.
REQ-003 SHALL hold an 8-bit wait_cnt; it counts cycles spent in MEM_WAIT.
REQ-004 Stall/flush outputs SHALL be combinational from the current state and the current inputs, with zero-cycle latency.
REQ-005 load_use SHALL be 1 when all of these hold:
- ex_reg_write=1, ex_result_src=2'b01 and ex_rd!=0.
- (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
REQ-006 Priority, highest first: TIMEOUT state, dmem_busy, ex_redirect, load_use.
REQ-007 In TIMEOUT, or when dmem_busy=1:
- All four stall outputs SHALL be 1.
- Both flush outputs SHALL be 0.
REQ-008 Otherwise, when ex_redirect=1:
- flush_ifid=1 and flush_idex=1.
- All stalls 0; load_use is ignored.
REQ-009 Otherwise, when load_use=1:
- stall_pc=1, stall_ifid=1, flush_idex=1 (one bubble).
- stall_idex=0, stall_exmem=0, flush_ifid=0.
REQ-010 Otherwise all six stall/flush outputs SHALL be 0.
REQ-011 A redirect arriving during dmem_busy SHALL NOT be latched. EX is frozen, so the redirect is acted on in the first cycle after dmem_busy falls.
REQ-012 State transitions:
- RUN -> MEM_WAIT when dmem_busy=1; wait_cnt <= 1.
- MEM_WAIT stays while dmem_busy=1; wait_cnt increments.
- MEM_WAIT -> RUN when dmem_busy=0; wait_cnt <= 0.
- MEM_WAIT -> TIMEOUT when dmem_busy=1 and wait_cnt==255; timeout_err <= 1.
- TIMEOUT is left only by rst.
REQ-013 wait_cnt SHALL never wrap; it holds 255 in TIMEOUT.
REQ-014 stall_cycles SHALL increment on each edge where stall_pc=1 and SHALL saturate at 16'hFFFF.
REQ-015 flush_events SHALL increment on each edge where REQ-008 applies and SHALL saturate at 16'hFFFF.
REQ-016 Register x0 SHALL never cause a load-use stall.

Reset
REQ-017 While rst=1 the block SHALL hold:
- state=RUN, wait_cnt=0, timeout_err=0, stall_cycles=0, flush_events=0.
- All stall/flush outputs 0, independent of inputs.
REQ-018 Asserting rst mid-MEM_WAIT or in TIMEOUT SHALL return the block to RUN immediately (asynchronously). Normal evaluation resumes on the first edge after release.

Verification
REQ-019 Load-use: ex_reg_write=1, ex_result_src=01, ex_rd=5, id_use_rs2=1, id_rs2=5 for one cycle.
-> stall_pc=1, stall_ifid=1, flush_idex=1 in that cycle; stall_cycles=1 after the edge.
REQ-020 x0 exclusion: the same stimulus with ex_rd=0 and id_rs1=0, id_use_rs1=1.
-> All outputs 0; stall_cycles unchanged.
REQ-021 Redirect plus load_use: ex_redirect=1 and load_use conditions true together.
-> flush_ifid=1, flush_idex=1, stall_pc=0; flush_events increments by 1.
REQ-022 Memory wait: dmem_busy=1 for 10 cycles, with ex_redirect=1 throughout.
-> Four stalls=1 and flushes=0 for 10 cycles; wait_cnt reaches 10.
-> Next cycle: RUN, flushes=1; stall_cycles=10.
REQ-023 Timeout: dmem_busy=1 for 300 cycles.
-> TIMEOUT entered on the edge after the 256th busy cycle; timeout_err=1.
-> Stalls stay 1 after dmem_busy=0.
-> rst pulse clears state, counters and timeout_err to 0.
REQ-024 Saturation: force 70000 consecutive load-use cycles.
-> stall_cycles reads 16'hFFFF and stays there.
